// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with a two-entry skid buffer; 1-cycle latency, full throughput.
// in_ready is registered (!skid_v); optional PIPE_STAT_EN adds saturating stall/bubble counters.
module pipe_stage_buf #(
  parameter int WIDTH = 165,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = !skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  assign in_fire  = in_valid & ~skid_v_q;
  assign out_fire = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = '0;
      skid_d   = '0;
    end else begin
      case ({main_v_q, skid_v_q})
        2'b00: begin
          if (in_fire) begin
            main_v_d = 1'b1;
            main_d   = in_data;
          end
        end
        2'b10: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
          end else if (out_fire) begin
            main_v_d = 1'b0;
            main_d   = '0;
          end
        end
        2'b11: begin
          if (out_fire) begin
            main_d   = skid_q;
            skid_d   = '0;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          // Skid-only cannot be reached; fall back to a clean bubble if it ever is.
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
          main_d   = '0;
          skid_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  skid_only_illegal: assert property (@(posedge clk) disable iff (reset) !(skid_v_q && !main_v_q));

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counted on pre-flush state; flush deliberately leaves the counters alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_v_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (!main_v_q && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the five-stage MIPS core, replacing the fixed enable/clear inter-stage registers with a generic valid/ready stage. It carries a payload bus (a concatenation of instr, operands, write address and PCs) of width `WIDTH`. It includes a two-entry skid buffer, so a downstream stall never costs a cycle of throughput and `in_ready` never depends combinationally on `out_ready`. It sits between any two pipeline stages (F/D, D/E, E/M, M/W). A flush clears it to a bubble (all-zero payload, which is a NOP in the datapath).

## Interface
Parameters:
- `WIDTH`, default 165: payload width in bits (5×32 + 5 for the M/W bundle).
- `CNT_W`, default 32: width of the statistics counters; only used with `PIPE_STAT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous clear to empty; drops all held entries.
- `in_valid`  in  1  upstream presents payload.
- `in_ready`  out  1  stage can accept; registered, depends on state only.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage holds a valid payload.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  payload; all-zero whenever `out_valid`=0.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0 (only with `PIPE_STAT_EN`).
- `bubble_cnt`  out  CNT_W  cycles with `out_valid`=0 (only with `PIPE_STAT_EN`).

## Operation
- Storage: main register (`main_q`, `main_v`) drives the output; skid register (`skid_q`, `skid_v`).
- Define `in_fire` = `in_valid` & `in_ready`, and `out_fire` = `out_valid` & `out_ready`.
- State is encoded by the valid bits:
  - EMPTY: `main_v`=0, `skid_v`=0.
  - ONE: `main_v`=1, `skid_v`=0.
  - FULL: `main_v`=1, `skid_v`=1.
- Skid-only is illegal. An assertion flags it in simulation.
- `in_ready` = !`skid_v`, so it is 1 in EMPTY and ONE and 0 in FULL.
- `out_valid` = `main_v`. `out_data` = `main_q`. `main_q` is forced to zero whenever the stage enters EMPTY.
- EMPTY transitions:
  - `in_fire` → ONE; `main_q` ← `in_data`.
  - otherwise → stay EMPTY.
- ONE transitions:
  - `in_fire` & `out_fire` → ONE; `main_q` ← `in_data`.
  - `in_fire` & !`out_fire` → FULL; `skid_q` ← `in_data`, `main_q` holds.
  - !`in_fire` & `out_fire` → EMPTY; `main_q` ← 0.
  - neither → hold.
- FULL transitions (no `in_fire` is possible):
  - `out_fire` → ONE; `main_q` ← `skid_q`, `skid_q` ← 0.
  - otherwise → hold both entries.
- Ordering is strictly FIFO. No payload is duplicated or lost except by `flush`/`reset`.
- Priority is `reset` > `flush` > handshake.
  - `flush` forces EMPTY and zeroes both registers.
  - A same-cycle `in_fire` or `out_fire` during `flush` is discarded. The upstream must treat its beat as consumed, since `in_ready` was 1.
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=1, skid=0, counters=0.
- A `reset` or `flush` asserted mid-operation in FULL still clears everything in one cycle.

## Timing
- Latency is 1 cycle: a beat fired at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 beat/cycle when `out_ready` is held high.
- After downstream stalls, recovery to full rate is immediate: FULL→ONE drains the skid while accepting again the next cycle.
- `in_ready` and `out_valid` are register outputs. There is no combinational path from `out_ready` or `in_valid` to any output.
- After `flush` at edge N: `out_valid`=0 and `in_ready`=1 from edge N on.

## Configuration
- Macro `PIPE_STAT_EN`.
- Defined:
  - `stall_cnt` and `bubble_cnt` increment once per qualifying cycle.
  - Both saturate at 2^CNT_W−1.
  - Both are cleared only by `reset`; `flush` does not clear them.
  - A `flush` cycle is counted by its pre-flush state.
- Undefined: counter logic is absent, and both ports are tied to 0.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles → `out_valid`=0, `out_data`=0, `in_ready`=1; `bubble_cnt`=0 after reset and increments by 1 per idle cycle (`PIPE_STAT_EN`).
- Streaming: `in_data`=1,2,3,4 on consecutive cycles with `out_ready`=1 → `out_data`=1,2,3,4 one cycle later, back-to-back, with `in_ready` constantly 1.
- Stall/skid: send A, B while `out_ready`=0 → `in_ready` drops after B; release `out_ready` → out A then B on consecutive cycles; `stall_cnt` equals the stalled cycles.
- Flush while FULL: hold A, B, then `flush`=1 with `in_valid`=1 (C) → next cycle `out_valid`=0, `out_data`=0, `in_ready`=1; A, B and C never appear.
- Random valid/ready: 10k cycles with random `in_valid`/`out_ready` → output sequence equals input sequence (scoreboard), and `in_ready` never goes high while in FULL.
- Counter saturation with `CNT_W`=4: stall 20 cycles → `stall_cnt`=15 and holds.
